// File: rtl/quant_stage_4x4.sv
`default_nettype none
// ============================================================================
// Module      : quant_stage_4x4
// Description : Scalar quantizer for a 4x4 block of forward-transform
//               coefficients. When started, it captures all 16 coefficients
//               together with the QP and intra flag. It then uses one shared
//               multiplier to quantize one coefficient per cycle in raster
//               order (00,01,..,33).
// Ports       : in_clk           clock, all state on rising edge
//               in_rst           asynchronous active-high reset
//               in_quant_start   start request, sampled only while idle
//               in_qp            quantization parameter (>51 clamped to 51)
//               in_intra         1: f = 2^qbits/3, 0: f = 2^qbits/6
//               in_T00..in_T33   signed transform coefficients
//               out_Z00..out_Z33 signed quantized levels, registered
//               out_busy         high while a block is in flight
//               out_done         one-cycle pulse, all 16 levels valid
// Revision    : 1.0 - initial release
// ============================================================================
module quant_stage_4x4 #(
  parameter int CW  = 15,
  parameter int MFW = 14,
  parameter int QPW = 6
) (
  input  logic           in_clk,
  input  logic           in_rst,
  input  logic           in_quant_start,
  input  logic [QPW-1:0] in_qp,
  input  logic           in_intra,
  input  logic [CW-1:0]  in_T00, in_T01, in_T02, in_T03,
  input  logic [CW-1:0]  in_T10, in_T11, in_T12, in_T13,
  input  logic [CW-1:0]  in_T20, in_T21, in_T22, in_T23,
  input  logic [CW-1:0]  in_T30, in_T31, in_T32, in_T33,
  output logic [CW-1:0]  out_Z00, out_Z01, out_Z02, out_Z03,
  output logic [CW-1:0]  out_Z10, out_Z11, out_Z12, out_Z13,
  output logic [CW-1:0]  out_Z20, out_Z21, out_Z22, out_Z23,
  output logic [CW-1:0]  out_Z30, out_Z31, out_Z32, out_Z33,
  output logic           out_busy,
  output logic           out_done
);

  localparam int PW = CW + MFW;  // |W|*MF product width
  localparam int SW = PW + 1;    // product plus rounding offset

  localparam logic [QPW-1:0] c_qp_max = QPW'(51);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_QUANT = 2'd2
  } state_t;

  state_t        r_state;
  logic [3:0]    r_idx;
  logic [CW-1:0] r_t [16];
  logic [CW-1:0] r_z [16];
  logic [3:0]    r_qp_div;
  logic [2:0]    r_qp_mod;
  logic          r_intra;
  logic          r_busy;
  logic          r_done;

  logic [CW-1:0]  w_t_in [16];
  logic [QPW-1:0] w_qp_clamped;
  logic [CW-1:0]  w_w;
  logic           w_neg;
  logic [CW-1:0]  w_abs;
  logic [MFW-1:0] w_mf;
  logic [4:0]     w_qbits;
  logic [SW-1:0]  w_pow;
  logic [SW-1:0]  w_f;
  logic [PW-1:0]  w_prod;
  logic [SW-1:0]  w_sum;
  logic [CW-1:0]  w_mag;
  logic [CW-1:0]  w_z;
  logic           w_class_a;
  logic           w_class_b;

  // Raster-order view of the coefficient inputs
  assign w_t_in[0]  = in_T00;  assign w_t_in[1]  = in_T01;
  assign w_t_in[2]  = in_T02;  assign w_t_in[3]  = in_T03;
  assign w_t_in[4]  = in_T10;  assign w_t_in[5]  = in_T11;
  assign w_t_in[6]  = in_T12;  assign w_t_in[7]  = in_T13;
  assign w_t_in[8]  = in_T20;  assign w_t_in[9]  = in_T21;
  assign w_t_in[10] = in_T22;  assign w_t_in[11] = in_T23;
  assign w_t_in[12] = in_T30;  assign w_t_in[13] = in_T31;
  assign w_t_in[14] = in_T32;  assign w_t_in[15] = in_T33;

  assign w_qp_clamped = (in_qp > c_qp_max) ? c_qp_max : in_qp;

  // Position class: A = even row and even column, B = odd row and odd column
  assign w_class_a = ~r_idx[2] & ~r_idx[0];
  assign w_class_b =  r_idx[2] &  r_idx[0];

  always_comb begin
    w_mf = MFW'(0);
    case (r_qp_mod)
      3'd0:    w_mf = w_class_a ? MFW'(13107) : (w_class_b ? MFW'(5243) : MFW'(8066));
      3'd1:    w_mf = w_class_a ? MFW'(11916) : (w_class_b ? MFW'(4660) : MFW'(7490));
      3'd2:    w_mf = w_class_a ? MFW'(10082) : (w_class_b ? MFW'(4194) : MFW'(6554));
      3'd3:    w_mf = w_class_a ? MFW'(9362)  : (w_class_b ? MFW'(3647) : MFW'(5825));
      3'd4:    w_mf = w_class_a ? MFW'(8192)  : (w_class_b ? MFW'(3355) : MFW'(5243));
      3'd5:    w_mf = w_class_a ? MFW'(7282)  : (w_class_b ? MFW'(2893) : MFW'(4559));
      default: w_mf = MFW'(0);
    endcase
  end

  // Magnitude as unsigned CW bits; the most negative input maps to 2^(CW-1)
  assign w_w     = r_t[r_idx];
  assign w_neg   = w_w[CW-1];
  assign w_abs   = w_neg ? (~w_w + CW'(1)) : w_w;

  assign w_qbits = 5'd15 + {1'b0, r_qp_div};
  assign w_pow   = SW'(1) << w_qbits;
  assign w_f     = r_intra ? (w_pow / SW'(3)) : (w_pow / SW'(6));

  assign w_prod  = PW'(w_abs) * PW'(w_mf);
  assign w_sum   = SW'(w_prod) + w_f;
  // The quotient never exceeds 6554, so CW bits hold it without loss
  assign w_mag   = CW'(w_sum >> w_qbits);
  assign w_z     = w_neg ? (-w_mag) : w_mag;

  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      r_state  <= S_IDLE;
      r_idx    <= 4'd0;
      r_qp_div <= 4'd0;
      r_qp_mod <= 3'd0;
      r_intra  <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      for (int i = 0; i < 16; i++) begin
        r_t[i] <= '0;
        r_z[i] <= '0;
      end
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (in_quant_start) begin
            r_state <= S_LOAD;
            r_busy  <= 1'b1;
          end
        end
        S_LOAD: begin
          for (int i = 0; i < 16; i++) begin
            r_t[i] <= w_t_in[i];
          end
          r_qp_div <= 4'(w_qp_clamped / QPW'(6));
          r_qp_mod <= 3'(w_qp_clamped % QPW'(6));
          r_intra  <= in_intra;
          r_idx    <= 4'd0;
          r_state  <= S_QUANT;
        end
        S_QUANT: begin
          r_z[r_idx] <= w_z;
          r_idx      <= r_idx + 4'd1;
          if (r_idx == 4'd15) begin
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign out_busy = r_busy;
  assign out_done = r_done;

  assign out_Z00 = r_z[0];   assign out_Z01 = r_z[1];
  assign out_Z02 = r_z[2];   assign out_Z03 = r_z[3];
  assign out_Z10 = r_z[4];   assign out_Z11 = r_z[5];
  assign out_Z12 = r_z[6];   assign out_Z13 = r_z[7];
  assign out_Z20 = r_z[8];   assign out_Z21 = r_z[9];
  assign out_Z22 = r_z[10];  assign out_Z23 = r_z[11];
  assign out_Z30 = r_z[12];  assign out_Z31 = r_z[13];
  assign out_Z32 = r_z[14];  assign out_Z33 = r_z[15];

endmodule
`default_nettype wire

// File: tb/tb_quant_stage_4x4.sv
`default_nettype none
// ============================================================================
// Module      : tb_quant_stage_4x4
// Description : Self-checking bench for quant_stage_4x4. Expected levels are
//               queued when a block is started and compared at out_done.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_quant_stage_4x4;

  localparam int CW = 15;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          intra;
  logic [5:0]    qp;
  logic [CW-1:0] t [16];
  logic [CW-1:0] z [16];
  logic          busy;
  logic          done;

  int checks = 0;
  int errors = 0;
  logic [CW-1:0] exp_q [$];

  always #5 clk = ~clk;

  quant_stage_4x4 dut (
    .in_clk(clk), .in_rst(rst), .in_quant_start(start), .in_qp(qp), .in_intra(intra),
    .in_T00(t[0]),  .in_T01(t[1]),  .in_T02(t[2]),  .in_T03(t[3]),
    .in_T10(t[4]),  .in_T11(t[5]),  .in_T12(t[6]),  .in_T13(t[7]),
    .in_T20(t[8]),  .in_T21(t[9]),  .in_T22(t[10]), .in_T23(t[11]),
    .in_T30(t[12]), .in_T31(t[13]), .in_T32(t[14]), .in_T33(t[15]),
    .out_Z00(z[0]),  .out_Z01(z[1]),  .out_Z02(z[2]),  .out_Z03(z[3]),
    .out_Z10(z[4]),  .out_Z11(z[5]),  .out_Z12(z[6]),  .out_Z13(z[7]),
    .out_Z20(z[8]),  .out_Z21(z[9]),  .out_Z22(z[10]), .out_Z23(z[11]),
    .out_Z30(z[12]), .out_Z31(z[13]), .out_Z32(z[14]), .out_Z33(z[15]),
    .out_busy(busy), .out_done(done)
  );

  // Reference quantizer written directly from the arithmetic definition
  function automatic logic [CW-1:0] model_z(input logic [CW-1:0] w, input int qp_in,
                                            input bit intra_in, input int pos);
    int     qpc, qdiv, qmod, qb, row, col;
    longint a, mf, f, mag;
    bit     cls_a, cls_b;
    qpc   = (qp_in > 51) ? 51 : qp_in;
    qdiv  = qpc / 6;
    qmod  = qpc % 6;
    qb    = 15 + qdiv;
    row   = pos / 4;
    col   = pos % 4;
    cls_a = (row % 2 == 0) && (col % 2 == 0);
    cls_b = (row % 2 == 1) && (col % 2 == 1);
    case (qmod)
      0: mf = cls_a ? 13107 : (cls_b ? 5243 : 8066);
      1: mf = cls_a ? 11916 : (cls_b ? 4660 : 7490);
      2: mf = cls_a ? 10082 : (cls_b ? 4194 : 6554);
      3: mf = cls_a ? 9362  : (cls_b ? 3647 : 5825);
      4: mf = cls_a ? 8192  : (cls_b ? 3355 : 5243);
      default: mf = cls_a ? 7282 : (cls_b ? 2893 : 4559);
    endcase
    a   = w[CW-1] ? (longint'(32768) - longint'(w)) : longint'(w);
    f   = (longint'(1) << qb) / (intra_in ? 3 : 6);
    mag = (a * mf + f) >>> qb;
    return w[CW-1] ? CW'(-mag) : CW'(mag);
  endfunction

  task automatic clear_inputs();
    for (int i = 0; i < 16; i++) t[i] = '0;
  endtask

  task automatic push_model();
    for (int i = 0; i < 16; i++) exp_q.push_back(model_z(t[i], int'(qp), intra, i));
  endtask

  task automatic randomize_inputs();
    for (int i = 0; i < 16; i++) t[i] = CW'($urandom);
    qp    = 6'($urandom_range(0, 63));
    intra = 1'($urandom_range(0, 1));
  endtask

  // Pulses start so that the next rising edge (E) samples it; returns just after E
  task automatic launch();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
  endtask

  // Returns k such that out_done was seen after edge E+k, 0 on timeout
  task automatic wait_done(output int lat);
    lat = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; qp = '0; intra = 1'b0;
    clear_inputs();
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (z[i] !== '0) begin errors++; $display("FAIL reset_z[%0d]: got %0d want 0", i, $signed(z[i])); end
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  // Runs one block with the given literal expectations and checks timing and levels
  task automatic test_directed(input string name, input logic [CW-1:0] exp_vals [16]);
    int lat;
    for (int i = 0; i < 16; i++) exp_q.push_back(exp_vals[i]);
    launch();
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL %s_busy: got %b want 1", name, busy); end
    wait_done(lat);
    checks++;
    if (lat != 17) begin errors++; $display("FAIL %s_latency: got %0d want 17", name, lat); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL %s_busy_at_done: got %b want 0", name, busy); end
    for (int i = 0; i < 16; i++) begin
      logic [CW-1:0] e;
      e = exp_q.pop_front();
      checks++;
      if (z[i] !== e) begin
        errors++;
        $display("FAIL %s_z[%0d]: got %0d want %0d", name, i, $signed(z[i]), $signed(e));
      end
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL %s_done_width: got %b want 0", name, done); end
  endtask

  task automatic test_basic();
    logic [CW-1:0] e [16];
    clear_inputs(); qp = 6'd0; intra = 1'b1;
    t[0] = 15'd100; t[1] = 15'd100; t[5] = 15'd100;
    for (int i = 0; i < 16; i++) e[i] = '0;
    e[0] = 15'd40; e[1] = 15'd24; e[5] = 15'd16;
    test_directed("basic", e);
  endtask

  task automatic test_negative();
    logic [CW-1:0] e [16];
    clear_inputs(); qp = 6'd0; intra = 1'b1;
    t[0] = 15'(-100); t[15] = 15'(-100);
    for (int i = 0; i < 16; i++) e[i] = '0;
    e[0] = 15'(-40); e[15] = 15'(-16);
    test_directed("negative", e);
  endtask

  task automatic test_rounding();
    logic [CW-1:0] e [16];
    clear_inputs(); qp = 6'd28; intra = 1'b1;
    t[0] = 15'd1003;
    for (int i = 0; i < 16; i++) e[i] = '0;
    e[0] = 15'd16;
    test_directed("round_intra", e);
    intra = 1'b0;
    e[0] = 15'd15;
    test_directed("round_inter", e);
  endtask

  task automatic test_clamp();
    logic [CW-1:0] e [16];
    clear_inputs(); qp = 6'd60; intra = 1'b1;
    t[0] = 15'd16383;
    for (int i = 0; i < 16; i++) e[i] = '0;
    e[0] = 15'd18;
    test_directed("clamp_pos", e);
    t[0] = 15'h4000;
    e[0] = 15'(-18);
    test_directed("clamp_neg", e);
  endtask

  task automatic test_back_to_back();
    int done_cnt = 0;
    int first_k  = 0;
    int second_k = 0;
    randomize_inputs();
    push_model();
    launch();
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        done_cnt++;
        if (done_cnt == 1) first_k = k; else if (done_cnt == 2) second_k = k;
        for (int i = 0; i < 16; i++) begin
          logic [CW-1:0] e;
          e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
          checks++;
          if (z[i] !== e) begin
            errors++;
            $display("FAIL b2b_z[%0d] (done %0d): got %0d want %0d", i, done_cnt, $signed(z[i]), $signed(e));
          end
        end
      end
      if (k == 5) begin
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL b2b_busy_mid: got %b want 1", busy); end
      end
      // Start sampled at E+5 while quantizing: must be ignored
      if (k == 4)  start = 1'b1;
      if (k == 5)  start = 1'b0;
      // Start sampled at E+18, the first idle edge after done
      if (k == 17) begin
        randomize_inputs();
        push_model();
        start = 1'b1;
      end
      if (k == 18) start = 1'b0;
    end
    checks++;
    if (done_cnt != 2) begin errors++; $display("FAIL b2b_done_count: got %0d want 2", done_cnt); end
    checks++;
    if (first_k != 17) begin errors++; $display("FAIL b2b_first_done: got %0d want 17", first_k); end
    checks++;
    if (second_k != 35) begin errors++; $display("FAIL b2b_second_done: got %0d want 35", second_k); end
    while (exp_q.size() > 0) void'(exp_q.pop_front());
  endtask

  task automatic test_reset_mid();
    int done_seen = 0;
    int lat;
    randomize_inputs();
    launch();
    repeat (7) @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b want 0", busy); end
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL midrst_done: got %b want 0", done); end
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (z[i] !== '0) begin errors++; $display("FAIL midrst_z[%0d]: got %0d want 0", i, $signed(z[i])); end
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (done === 1'b1) done_seen++;
    end
    checks++;
    if (done_seen != 0) begin errors++; $display("FAIL midrst_no_done: got %0d pulses want 0", done_seen); end
    // A fresh block after the abort must complete normally
    randomize_inputs();
    push_model();
    launch();
    wait_done(lat);
    checks++;
    if (lat != 17) begin errors++; $display("FAIL midrst_recover_latency: got %0d want 17", lat); end
    for (int i = 0; i < 16; i++) begin
      logic [CW-1:0] e;
      e = exp_q.pop_front();
      checks++;
      if (z[i] !== e) begin errors++; $display("FAIL midrst_recover_z[%0d]: got %0d want %0d", i, $signed(z[i]), $signed(e)); end
    end
  endtask

  task automatic test_random();
    int lat;
    for (int n = 0; n < 6; n++) begin
      randomize_inputs();
      if (n == 0) begin t[3] = 15'h4000; t[10] = 15'h3FFF; end
      push_model();
      launch();
      wait_done(lat);
      checks++;
      if (lat != 17) begin errors++; $display("FAIL rand%0d_latency: got %0d want 17", n, lat); end
      for (int i = 0; i < 16; i++) begin
        logic [CW-1:0] e;
        e = exp_q.pop_front();
        checks++;
        if (z[i] !== e) begin
          errors++;
          $display("FAIL rand%0d_z[%0d]: got %0d want %0d (qp %0d intra %0d T %0d)",
                   n, i, $signed(z[i]), $signed(e), qp, intra, $signed(t[i]));
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_negative();
    test_rounding();
    test_clamp();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d errors %0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
